wb_arbiter_2m_1s: RTL and testbench

- Shares one Wishbone slave port between two Wishbone masters, e.g. CPU instruction and data ports feeding the slave-side 1-master/2-slave address decoder.
- Round-robin grant, held for the whole bus cycle (CYC high).
- A per-transfer watchdog returns ERR to the owning master when the slave never responds.

---
 rtl/wb_pkg.sv | 13 +
 rtl/wb_watchdog.sv | 42 ++++
 rtl/wb_arbiter_2m_1s.sv | 143 ++++++++++++++
 tb/tb_wb_arbiter_2m_1s.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared definitions for the two-master Wishbone arbiter.
//   - Owner/state encoding, identical to the one-hot grant_o value
//     (IDLE = 00, OWN0 = 01, OWN1 = 10).
//   - Wishbone byte-select width.
package wb_pkg;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_OWN0 = 2'b01;
    localparam logic [1:0] ST_OWN1 = 2'b10;

    localparam int SEL_WIDTH = 4;

endpackage

// File: rtl/wb_watchdog.sv
// Per-transfer bus watchdog.
// Counts cycles in which the bus owner holds STB with no slave response. When
// the count reaches TIMEOUT it raises err_o for one cycle and starts over.
// A slave response in that same cycle wins, and err_o stays low.
// TIMEOUT = 0 disables the watchdog.
//
// Ports:
//   clk_i   in  system clock
//   rst_i   in  synchronous reset, active-high
//   clear_i in  bus idle (no owner); holds the counter at zero
//   stb_i   in  strobe of the current owner
//   resp_i  in  any slave response (ACK | ERR | RTY)
//   err_o   out one-cycle timeout pulse
module wb_watchdog #(
    parameter int TIMEOUT  = 255,
    parameter int TO_WIDTH = 8
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic stb_i,
    input  logic resp_i,
    output logic err_o
);

    localparam logic [TO_WIDTH-1:0] LIMIT   = TO_WIDTH'(TIMEOUT);
    localparam bit                  ENABLED = (TIMEOUT != 0);

    logic [TO_WIDTH-1:0] count;

    assign err_o = ENABLED && stb_i && !clear_i && !resp_i && (count == LIMIT);

    // NOTE: sequential state is always written with non-blocking (<=) so every
    // flop samples its inputs from before the edge, whatever the block order.
    always_ff @(posedge clk_i) begin
        if (rst_i || !ENABLED || clear_i || !stb_i || resp_i || err_o)
            count <= '0;
        else
            count <= count + TO_WIDTH'(1);
    end

endmodule

// File: rtl/wb_arbiter_2m_1s.sv
// Two-master / one-slave Wishbone arbiter.
// Round-robin grant. The grant is held for the whole bus cycle (CYC high), and
// every ownership change passes through one IDLE cycle. The slave side is a
// combinational mux driven by the registered owner. A watchdog answers a silent
// slave with ERR to the owning master.
//
// Ports:
//   clk_i, rst_i                     clock, synchronous active-high reset
//   mN_addr_i/data_i/sel_i/we_i      master N request (N = 0, 1)
//   mN_cyc_i, mN_stb_i               master N cycle / strobe
//   mN_data_o                        read data (s_data_i, qualify with ACK)
//   mN_ack_o/err_o/rty_o             responses, only to the current owner
//   s_addr_o/data_o/sel_o/we_o       request to slave side
//   s_cyc_o, s_stb_o                 slave cycle / strobe
//   s_data_i, s_ack_i/err_i/rty_i    slave read data and responses
//   grant_o                          one-hot owner, 00 = idle
import wb_pkg::*;

module wb_arbiter_2m_1s #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 255,
    parameter int TO_WIDTH   = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,

    input  logic [ADDR_WIDTH-1:0] m0_addr_i,
    input  logic [DATA_WIDTH-1:0] m0_data_i,
    output logic [DATA_WIDTH-1:0] m0_data_o,
    input  logic                  m0_cyc_i,
    input  logic                  m0_stb_i,
    input  logic                  m0_we_i,
    input  logic [SEL_WIDTH-1:0]  m0_sel_i,
    output logic                  m0_ack_o,
    output logic                  m0_err_o,
    output logic                  m0_rty_o,

    input  logic [ADDR_WIDTH-1:0] m1_addr_i,
    input  logic [DATA_WIDTH-1:0] m1_data_i,
    output logic [DATA_WIDTH-1:0] m1_data_o,
    input  logic                  m1_cyc_i,
    input  logic                  m1_stb_i,
    input  logic                  m1_we_i,
    input  logic [SEL_WIDTH-1:0]  m1_sel_i,
    output logic                  m1_ack_o,
    output logic                  m1_err_o,
    output logic                  m1_rty_o,

    output logic [ADDR_WIDTH-1:0] s_addr_o,
    output logic [DATA_WIDTH-1:0] s_data_o,
    input  logic [DATA_WIDTH-1:0] s_data_i,
    output logic                  s_cyc_o,
    output logic                  s_stb_o,
    output logic                  s_we_o,
    output logic [SEL_WIDTH-1:0]  s_sel_o,
    input  logic                  s_ack_i,
    input  logic                  s_err_i,
    input  logic                  s_rty_i,

    output logic [1:0]            grant_o
);

    logic [1:0] state, state_nxt;
    // 0 = master 0 was granted last, 1 = master 1 was granted last.
    logic       last_owner, last_owner_nxt;
    logic       own0, own1;
    logic       owner_cyc, owner_stb;
    logic       resp_any;
    logic       wd_err;

    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path through the case can leave it unassigned and infer a latch.
    always_comb begin
        state_nxt      = state;
        last_owner_nxt = last_owner;
        case (state)
            ST_IDLE: begin
                if (m0_cyc_i && m1_cyc_i)
                    state_nxt = last_owner ? ST_OWN0 : ST_OWN1;
                else if (m0_cyc_i)
                    state_nxt = ST_OWN0;
                else if (m1_cyc_i)
                    state_nxt = ST_OWN1;
                if (state_nxt == ST_OWN0) last_owner_nxt = 1'b0;
                if (state_nxt == ST_OWN1) last_owner_nxt = 1'b1;
            end
            ST_OWN0: if (!m0_cyc_i) state_nxt = ST_IDLE;
            ST_OWN1: if (!m1_cyc_i) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= ST_IDLE;
            last_owner <= 1'b1;     // master 0 wins the first tie
        end else begin
            state      <= state_nxt;
            last_owner <= last_owner_nxt;
        end
    end

    assign own0      = (state == ST_OWN0);
    assign own1      = (state == ST_OWN1);
    assign grant_o   = state;
    assign owner_cyc = (own0 & m0_cyc_i) | (own1 & m1_cyc_i);
    assign owner_stb = (own0 & m0_stb_i) | (own1 & m1_stb_i);
    assign resp_any  = s_ack_i | s_err_i | s_rty_i;

    // Address, data and sel are don't-care when idle, so master 0 is the
    // default leg. WE is forced low when idle, so the slave sees no write.
    assign s_addr_o = own1 ? m1_addr_i : m0_addr_i;
    assign s_data_o = own1 ? m1_data_i : m0_data_i;
    assign s_sel_o  = own1 ? m1_sel_i  : m0_sel_i;
    assign s_we_o   = (own0 & m0_we_i) | (own1 & m1_we_i);
    assign s_cyc_o  = owner_cyc;
    // Strobe is withdrawn in the timeout cycle so the dead transfer ends.
    assign s_stb_o  = owner_stb & ~wd_err;

    // Responses go only to the owner. Anything arriving in IDLE is dropped.
    assign m0_data_o = s_data_i;
    assign m1_data_o = s_data_i;
    assign m0_ack_o  = own0 & s_ack_i;
    assign m0_err_o  = own0 & (s_err_i | wd_err);
    assign m0_rty_o  = own0 & s_rty_i;
    assign m1_ack_o  = own1 & s_ack_i;
    assign m1_err_o  = own1 & (s_err_i | wd_err);
    assign m1_rty_o  = own1 & s_rty_i;

    wb_watchdog #(
        .TIMEOUT  (TIMEOUT),
        .TO_WIDTH (TO_WIDTH)
    ) u_watchdog (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clear_i (state == ST_IDLE),
        .stb_i   (owner_stb),
        .resp_i  (resp_any),
        .err_o   (wd_err)
    );

endmodule

// File: tb/tb_wb_arbiter_2m_1s.sv
// Directed bench for wb_arbiter_2m_1s. The main instance uses TIMEOUT = 8. A
// second instance with TIMEOUT = 0 shares all inputs and must never raise ERR.
module tb_wb_arbiter_2m_1s;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] m0_addr_i, m0_data_i, m1_addr_i, m1_data_i, s_data_i;
    logic        m0_cyc_i, m0_stb_i, m0_we_i, m1_cyc_i, m1_stb_i, m1_we_i;
    logic [3:0]  m0_sel_i, m1_sel_i;
    logic        s_ack_i, s_err_i, s_rty_i;

    logic [31:0] m0_data_o, m1_data_o, s_addr_o, s_data_o;
    logic        m0_ack_o, m0_err_o, m0_rty_o, m1_ack_o, m1_err_o, m1_rty_o;
    logic        s_cyc_o, s_stb_o, s_we_o;
    logic [3:0]  s_sel_o;
    logic [1:0]  grant_o;

    logic [31:0] nt_m0_data_o, nt_m1_data_o, nt_s_addr_o, nt_s_data_o;
    logic        nt_m0_ack_o, nt_m0_err_o, nt_m0_rty_o;
    logic        nt_m1_ack_o, nt_m1_err_o, nt_m1_rty_o;
    logic        nt_s_cyc_o, nt_s_stb_o, nt_s_we_o;
    logic [3:0]  nt_s_sel_o;
    logic [1:0]  nt_grant_o;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    wb_arbiter_2m_1s #(.TIMEOUT(8), .TO_WIDTH(8)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .m0_addr_i(m0_addr_i), .m0_data_i(m0_data_i), .m0_data_o(m0_data_o),
        .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i), .m0_sel_i(m0_sel_i),
        .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o), .m0_rty_o(m0_rty_o),
        .m1_addr_i(m1_addr_i), .m1_data_i(m1_data_i), .m1_data_o(m1_data_o),
        .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i), .m1_sel_i(m1_sel_i),
        .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o), .m1_rty_o(m1_rty_o),
        .s_addr_o(s_addr_o), .s_data_o(s_data_o), .s_data_i(s_data_i),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
        .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_rty_i(s_rty_i),
        .grant_o(grant_o)
    );

    wb_arbiter_2m_1s #(.TIMEOUT(0), .TO_WIDTH(8)) dut_nt (
        .clk_i(clk_i), .rst_i(rst_i),
        .m0_addr_i(m0_addr_i), .m0_data_i(m0_data_i), .m0_data_o(nt_m0_data_o),
        .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i), .m0_sel_i(m0_sel_i),
        .m0_ack_o(nt_m0_ack_o), .m0_err_o(nt_m0_err_o), .m0_rty_o(nt_m0_rty_o),
        .m1_addr_i(m1_addr_i), .m1_data_i(m1_data_i), .m1_data_o(nt_m1_data_o),
        .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i), .m1_sel_i(m1_sel_i),
        .m1_ack_o(nt_m1_ack_o), .m1_err_o(nt_m1_err_o), .m1_rty_o(nt_m1_rty_o),
        .s_addr_o(nt_s_addr_o), .s_data_o(nt_s_data_o), .s_data_i(s_data_i),
        .s_cyc_o(nt_s_cyc_o), .s_stb_o(nt_s_stb_o), .s_we_o(nt_s_we_o), .s_sel_o(nt_s_sel_o),
        .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_rty_i(s_rty_i),
        .grant_o(nt_grant_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Step past the next rising edge. Inputs change and outputs are sampled
    // 1 time unit after the edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        rst_i = 1'b1;
        m0_addr_i = '0; m0_data_i = '0; m0_cyc_i = 0; m0_stb_i = 0; m0_we_i = 0; m0_sel_i = 4'hF;
        m1_addr_i = '0; m1_data_i = '0; m1_cyc_i = 0; m1_stb_i = 0; m1_we_i = 0; m1_sel_i = 4'hF;
        s_data_i = '0; s_ack_i = 0; s_err_i = 0; s_rty_i = 0;

        // ---- reset state
        tick(); tick();
        check("rst_grant", 32'(grant_o), 32'h0);
        check("rst_s_cyc", 32'(s_cyc_o), 32'h0);
        check("rst_s_stb", 32'(s_stb_o), 32'h0);
        check("rst_s_we",  32'(s_we_o),  32'h0);
        check("rst_resp",  32'({m0_ack_o, m0_err_o, m0_rty_o, m1_ack_o, m1_err_o, m1_rty_o}), 32'h0);
        rst_i = 1'b0;

        // ---- m0 single read at 0x10, slave acks one cycle later
        m0_addr_i = 32'h0000_0010; m0_cyc_i = 1; m0_stb_i = 1;
        #1 check("rd_grant_before", 32'(grant_o), 32'h0);
        tick();
        check("rd_grant", 32'(grant_o), 32'h1);
        check("rd_s_stb", 32'(s_stb_o), 32'h1);
        check("rd_s_addr", s_addr_o, 32'h0000_0010);
        tick();
        s_ack_i = 1; s_data_i = 32'hDEAD_BEEF;
        #1;
        check("rd_m0_ack", 32'(m0_ack_o), 32'h1);
        check("rd_m0_data", m0_data_o, 32'hDEAD_BEEF);
        check("rd_m1_ack", 32'(m1_ack_o), 32'h0);
        tick();
        s_ack_i = 0; m0_cyc_i = 0; m0_stb_i = 0;
        tick();
        check("rd_release", 32'(grant_o), 32'h0);

        // ---- simultaneous requests after reset, round-robin
        rst_i = 1; tick(); rst_i = 0;
        m0_cyc_i = 1; m1_cyc_i = 1;
        tick();
        check("rr_first_m0", 32'(grant_o), 32'h1);
        m0_cyc_i = 0;
        tick();
        check("rr_idle_gap", 32'(grant_o), 32'h0);
        tick();
        check("rr_then_m1", 32'(grant_o), 32'h2);
        m1_cyc_i = 0;
        tick();
        check("rr_idle2", 32'(grant_o), 32'h0);
        m0_cyc_i = 1; m1_cyc_i = 1;
        tick();
        check("rr_second_m0", 32'(grant_o), 32'h1);
        m0_cyc_i = 0; m1_cyc_i = 0;
        tick();

        // ---- m1 burst write while m0 waits
        m1_cyc_i = 1;
        tick();
        check("bu_grant", 32'(grant_o), 32'h2);
        m0_cyc_i = 1; m0_stb_i = 1; m0_addr_i = 32'h0000_BAD0;
        for (int i = 0; i < 4; i++) begin
            m1_stb_i = 1; m1_we_i = 1;
            m1_addr_i = 32'h100 + 32'(4 * i);
            m1_data_i = 32'(i + 1);
            s_ack_i = 1;
            #1;
            check("bu_s_addr", s_addr_o, 32'h100 + 32'(4 * i));
            check("bu_s_data", s_data_o, 32'(i + 1));
            check("bu_s_we", 32'(s_we_o), 32'h1);
            check("bu_m1_ack", 32'(m1_ack_o), 32'h1);
            check("bu_m0_ack", 32'(m0_ack_o), 32'h0);
            tick();
        end
        m1_cyc_i = 0; m1_stb_i = 0; m1_we_i = 0; s_ack_i = 0;
        #1 check("bu_drop_addr", s_addr_o, 32'h0000_010C);
        tick();
        check("bu_idle", 32'(grant_o), 32'h0);
        check("bu_idle_stb", 32'(s_stb_o), 32'h0);
        tick();
        check("bu_m0_grant", 32'(grant_o), 32'h1);
        check("bu_m0_addr", s_addr_o, 32'h0000_BAD0);

        // ---- watchdog: m0 strobes, slave silent; err 8 cycles after first stb
        for (int k = 0; k < 10; k++) begin
            check("wd_m0_err", 32'(m0_err_o), 32'(k == 8));
            check("wd_s_stb", 32'(s_stb_o), 32'(k != 8));
            check("wd_nt_err", 32'(nt_m0_err_o), 32'h0);
            tick();
        end

        // ---- ack in the same cycle the counter reaches TIMEOUT
        m0_cyc_i = 0; m0_stb_i = 0;
        tick();
        m0_cyc_i = 1; m0_stb_i = 1;
        tick();
        repeat (8) tick();
        s_ack_i = 1; s_data_i = 32'h1234_5678;
        #1;
        check("co_m0_ack", 32'(m0_ack_o), 32'h1);
        check("co_m0_err", 32'(m0_err_o), 32'h0);
        check("co_s_stb", 32'(s_stb_o), 32'h1);
        s_ack_i = 0; m0_cyc_i = 0; m0_stb_i = 0;
        tick();

        // ---- reset mid-transfer of m1
        m1_cyc_i = 1; m1_stb_i = 1; m1_we_i = 1; m1_addr_i = 32'h200;
        tick();
        check("mr_grant_m1", 32'(grant_o), 32'h2);
        rst_i = 1; s_ack_i = 1;
        tick();
        rst_i = 0; m0_cyc_i = 1;
        #1;
        check("mr_grant", 32'(grant_o), 32'h0);
        check("mr_s_cyc", 32'(s_cyc_o), 32'h0);
        check("mr_s_stb", 32'(s_stb_o), 32'h0);
        check("mr_acks", 32'({m0_ack_o, m1_ack_o}), 32'h0);
        s_ack_i = 0;
        tick();
        check("mr_regrant_m0", 32'(grant_o), 32'h1);
        check("mr_s_addr", s_addr_o, 32'h0000_BAD0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
